// File: rtl/cpu_nx1_arbiter_pkg.sv
// Shared types for the N-to-1 CPU-bus arbiter: FSM state encoding and the
// latched request record.
package cpu_bus_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // Widths here must match the arbiter's ADDR_WIDTH/DATA_WIDTH parameters.
  typedef struct packed {
    logic                  write;
    logic                  read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
  } cpu_req_t;

endpackage

// File: rtl/cpu_nx1_arbiter_if.sv
// Bundle of the upstream (per-master) and downstream CPU-bus signals around
// the arbiter. 'slave' is the arbiter's view (it serves the masters and
// drives the downstream command); 'master' is the surrounding environment.
interface cpu_nx1_arbiter_if #(
  parameter int MASTER_NO  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [MASTER_NO-1:0]                 cpu_s_write;
  logic [MASTER_NO-1:0]                 cpu_s_read;
  logic [MASTER_NO-1:0][ADDR_WIDTH-1:0] cpu_s_address;
  logic [MASTER_NO-1:0][DATA_WIDTH-1:0] cpu_s_write_data;
  logic [MASTER_NO-1:0][DATA_WIDTH-1:0] cpu_s_read_data;
  logic [MASTER_NO-1:0]                 cpu_s_access_ready;
  logic [MASTER_NO-1:0]                 cpu_s_access_complete;

  logic                  cpu_m_write;
  logic                  cpu_m_read;
  logic [ADDR_WIDTH-1:0] cpu_m_address;
  logic [DATA_WIDTH-1:0] cpu_m_write_data;
  logic [DATA_WIDTH-1:0] cpu_m_read_data;
  logic                  cpu_m_access_ready;
  logic                  cpu_m_access_complete;

  modport slave (
    input  cpu_s_write, cpu_s_read, cpu_s_address, cpu_s_write_data,
    output cpu_s_read_data, cpu_s_access_ready, cpu_s_access_complete,
    output cpu_m_write, cpu_m_read, cpu_m_address, cpu_m_write_data,
    input  cpu_m_read_data, cpu_m_access_ready, cpu_m_access_complete
  );

  modport master (
    output cpu_s_write, cpu_s_read, cpu_s_address, cpu_s_write_data,
    input  cpu_s_read_data, cpu_s_access_ready, cpu_s_access_complete,
    input  cpu_m_write, cpu_m_read, cpu_m_address, cpu_m_write_data,
    output cpu_m_read_data, cpu_m_access_ready, cpu_m_access_complete
  );

endinterface

// File: rtl/cpu_nx1_arbiter_picker.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping from MASTER_NO-1 back to 0.
module cpu_rr_picker #(
  parameter int MASTER_NO  = 4,
  parameter int MIDX_WIDTH = $clog2(MASTER_NO)
) (
  input  logic [MASTER_NO-1:0]  req,
  input  logic [MIDX_WIDTH-1:0] ptr,
  output logic [MIDX_WIDTH-1:0] grant,
  output logic                  any_req
);

  int                    sum;
  logic [MIDX_WIDTH-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest request to ptr wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    grant   = ptr;
    any_req = |req;
    sum     = 0;
    cand    = '0;
    for (int off = MASTER_NO - 1; off >= 0; off--) begin
      sum  = int'(ptr) + off;
      cand = MIDX_WIDTH'((sum >= MASTER_NO) ? sum - MASTER_NO : sum);
      if (req[cand]) grant = cand;
    end
  end

endmodule

// File: rtl/cpu_nx1_arbiter.sv
// N-to-1 CPU-bus arbiter: round-robin grant, one outstanding transaction,
// registered downstream command and registered upstream response.
module cpu_nx1_arbiter #(
  parameter int MASTER_NO  = 4,
  parameter int MIDX_WIDTH = $clog2(MASTER_NO),
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_nx1_arbiter_if.slave      bus,
  output logic                  arb_busy,
  output logic [MIDX_WIDTH-1:0] arb_grant_id
);

  import cpu_bus_pkg::*;

  arb_state_e            state_q, state_d;
  logic [MIDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [MIDX_WIDTH-1:0] grant_q, grant_d;
  cpu_req_t              req_q, req_d;
  logic                  m_write_q, m_write_d;
  logic                  m_read_q, m_read_d;
  logic [MASTER_NO-1:0]  s_ready_q, s_ready_d;
  logic [MASTER_NO-1:0]  s_complete_q, s_complete_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [MIDX_WIDTH-1:0] pick;
  logic                  any_req;
  logic                  done;

  cpu_rr_picker #(
    .MASTER_NO  (MASTER_NO),
    .MIDX_WIDTH (MIDX_WIDTH)
  ) u_picker (
    .req     (bus.cpu_s_write | bus.cpu_s_read),
    .ptr     (ptr_q),
    .grant   (pick),
    .any_req (any_req)
  );

  // Next-state, latch and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    req_d        = req_q;
    m_write_d    = 1'b0;
    m_read_d     = 1'b0;
    s_ready_d    = '0;
    s_complete_d = '0;
    rdata_d      = rdata_q;
    done         = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d          = pick;
          ptr_d            = (pick == MIDX_WIDTH'(MASTER_NO - 1)) ? '0 : pick + 1'b1;
          // A simultaneous read+write request is treated as a write.
          req_d.write      = bus.cpu_s_write[pick];
          req_d.read       = bus.cpu_s_read[pick] & ~bus.cpu_s_write[pick];
          req_d.address    = bus.cpu_s_address[pick];
          req_d.write_data = bus.cpu_s_write_data[pick];
          m_write_d        = req_d.write;
          m_read_d         = req_d.read;
          s_ready_d[pick]  = 1'b1;
          state_d          = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bus.cpu_m_access_ready) begin
          // Ready together with complete is a zero-wait slave: finish now.
          if (bus.cpu_m_access_complete) done = 1'b1;
          else                           state_d = ARB_WAIT;
        end else begin
          m_write_d = req_q.write;
          m_read_d  = req_q.read;
        end
      end
      ARB_WAIT: done = bus.cpu_m_access_complete;
      default:  state_d = ARB_IDLE;
    endcase

    if (done) begin
      state_d               = ARB_IDLE;
      s_complete_d[grant_q] = 1'b1;
      if (req_q.read) rdata_d = bus.cpu_m_read_data;
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      req_q        <= '0;
      m_write_q    <= 1'b0;
      m_read_q     <= 1'b0;
      s_ready_q    <= '0;
      s_complete_q <= '0;
      rdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      req_q        <= req_d;
      m_write_q    <= m_write_d;
      m_read_q     <= m_read_d;
      s_ready_q    <= s_ready_d;
      s_complete_q <= s_complete_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.cpu_m_write           = m_write_q;
  assign bus.cpu_m_read            = m_read_q;
  assign bus.cpu_m_address         = req_q.address;
  assign bus.cpu_m_write_data      = req_q.write_data;
  assign bus.cpu_s_read_data       = {MASTER_NO{rdata_q}};
  assign bus.cpu_s_access_ready    = s_ready_q;
  assign bus.cpu_s_access_complete = s_complete_q;
  assign arb_busy                  = (state_q != ARB_IDLE);
  assign arb_grant_id              = grant_q;

endmodule

// File: tb/tb_cpu_nx1_arbiter.sv
// Directed bench for cpu_nx1_arbiter: a vector table for the basic read and
// write paths, plus hand-written stall, reset and round-robin sequences.
module tb_cpu_nx1_arbiter;

  logic       clk;
  logic       reset;
  logic       arb_busy;
  logic [1:0] arb_grant_id;

  int checks = 0;
  int errors = 0;

  cpu_nx1_arbiter_if #(.MASTER_NO(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cpu_nx1_arbiter #(
    .MASTER_NO  (4),
    .MIDX_WIDTH (2),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .arb_busy     (arb_busy),
    .arb_grant_id (arb_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  w;
    logic [3:0]  r;
    int          mi;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        cpl;
    logic [31:0] rdata;
    logic        e_mw;
    logic        e_mr;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_srdy;
    logic [3:0]  e_scpl;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[12];
  int   rr_order[5] = '{0, 1, 2, 3, 0};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master mi carries addr/wdata; the others carry distinct filler values.
  task automatic drive(logic [3:0] w, logic [3:0] r, int mi, logic [31:0] addr,
                       logic [31:0] wdata, logic rdy, logic cpl, logic [31:0] rdata);
    bus.cpu_s_write = w;
    bus.cpu_s_read  = r;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_s_address[i[1:0]]    = (i == mi) ? addr  : (32'hF000_0000 | 32'(i));
      bus.cpu_s_write_data[i[1:0]] = (i == mi) ? wdata : (32'hA500_0000 | 32'(i));
    end
    bus.cpu_m_access_ready    = rdy;
    bus.cpu_m_access_complete = cpl;
    bus.cpu_m_read_data       = rdata;
  endtask

  task automatic drive_idle();
    drive(4'b0, 4'b0, -1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_out(string tag, logic emw, logic emr, logic [31:0] eaddr,
                           logic [31:0] ewd, logic [3:0] esr, logic [3:0] esc,
                           logic eb, logic [1:0] eg, logic [31:0] erd);
    check({tag, " m_write"}, 32'(bus.cpu_m_write), 32'(emw));
    check({tag, " m_read"}, 32'(bus.cpu_m_read), 32'(emr));
    check({tag, " m_address"}, bus.cpu_m_address, eaddr);
    check({tag, " m_write_data"}, bus.cpu_m_write_data, ewd);
    check({tag, " s_access_ready"}, 32'(bus.cpu_s_access_ready), 32'(esr));
    check({tag, " s_access_complete"}, 32'(bus.cpu_s_access_complete), 32'(esc));
    check({tag, " arb_busy"}, 32'(arb_busy), 32'(eb));
    check({tag, " arb_grant_id"}, 32'(arb_grant_id), 32'(eg));
    for (int i = 0; i < 4; i++)
      check($sformatf("%s s_read_data[%0d]", tag, i), bus.cpu_s_read_data[i[1:0]], erd);
  endtask

  initial begin
    int n_acc;
    int last_c;

    // Master 2 read with one ready cycle and a later complete, a stray
    // complete while idle, then master 1 write+read on a zero-wait slave.
    //            w        r       mi addr          wdata         rdy   cpl   rdata
    //            mw    mr    addr          wd            srdy     scpl     busy  gid   rd
    vecs[0]  = '{4'b0000, 4'b0100, 2, 32'h0010_0040, 32'h0,        1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,         32'h0,        4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{4'b0000, 4'b0100, 2, 32'h0010_0040, 32'h0,        1'b1, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h0010_0040, 32'h0,        4'b0100, 4'b0000, 1'b1, 2'd2, 32'h0};
    vecs[2]  = '{4'b0000, 4'b0000, 2, 32'h0010_0040, 32'h0,        1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0010_0040, 32'h0,        4'b0000, 4'b0000, 1'b1, 2'd2, 32'h0};
    vecs[3]  = '{4'b0000, 4'b0000, 2, 32'h0010_0040, 32'h0,        1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0010_0040, 32'h0,        4'b0000, 4'b0000, 1'b1, 2'd2, 32'h0};
    vecs[4]  = '{4'b0000, 4'b0000, 2, 32'h0010_0040, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF,
                 1'b0, 1'b0, 32'h0010_0040, 32'h0,        4'b0000, 4'b0000, 1'b1, 2'd2, 32'h0};
    vecs[5]  = '{4'b0000, 4'b0000, -1, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0010_0040, 32'h0,        4'b0000, 4'b0100, 1'b0, 2'd2, 32'hDEAD_BEEF};
    vecs[6]  = '{4'b0000, 4'b0000, -1, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0BAD_0BAD,
                 1'b0, 1'b0, 32'h0010_0040, 32'h0,        4'b0000, 4'b0000, 1'b0, 2'd2, 32'hDEAD_BEEF};
    vecs[7]  = '{4'b0000, 4'b0000, -1, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0010_0040, 32'h0,        4'b0000, 4'b0000, 1'b0, 2'd2, 32'hDEAD_BEEF};
    vecs[8]  = '{4'b0010, 4'b0010, 1, 32'h0000_0100, 32'h1234_5678, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0010_0040, 32'h0,        4'b0000, 4'b0000, 1'b0, 2'd2, 32'hDEAD_BEEF};
    vecs[9]  = '{4'b0010, 4'b0010, 1, 32'h0000_0100, 32'h1234_5678, 1'b1, 1'b1, 32'h5555_5555,
                 1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'b0010, 4'b0000, 1'b1, 2'd1, 32'hDEAD_BEEF};
    vecs[10] = '{4'b0000, 4'b0000, -1, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'b0000, 4'b0010, 1'b0, 2'd1, 32'hDEAD_BEEF};
    vecs[11] = '{4'b0000, 4'b0000, -1, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'b0000, 4'b0000, 1'b0, 2'd1, 32'hDEAD_BEEF};

    // Reset, then ten quiet cycles.
    reset = 1'b0;
    drive_idle();
    repeat (3) tick();
    check_out("in_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_out($sformatf("idle%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Vector table: check this cycle's outputs, then apply this cycle's inputs.
    for (int k = 0; k < 12; k++) begin
      check_out($sformatf("vec%0d", k), vecs[k].e_mw, vecs[k].e_mr, vecs[k].e_addr,
                vecs[k].e_wd, vecs[k].e_srdy, vecs[k].e_scpl, vecs[k].e_busy,
                vecs[k].e_gid, vecs[k].e_rd);
      drive(vecs[k].w, vecs[k].r, vecs[k].mi, vecs[k].addr, vecs[k].wdata,
            vecs[k].rdy, vecs[k].cpl, vecs[k].rdata);
      tick();
    end

    // Stall: master 3 write, slave withholds ready for 5 ISSUE cycles.
    drive(4'b1000, 4'b0000, 3, 32'h0000_3000, 32'hCAFE_0003, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("stall_issue", 1, 0, 32'h0000_3000, 32'hCAFE_0003, 4'b1000, 0, 1, 3, 32'hDEAD_BEEF);
    drive(4'b0000, 4'b0000, 3, 32'h0000_3000, 32'hCAFE_0003, 1'b0, 1'b0, 32'h0);
    tick();
    for (int j = 0; j < 5; j++) begin
      check_out($sformatf("stall_hold%0d", j), 1, 0, 32'h0000_3000, 32'hCAFE_0003,
                0, 0, 1, 3, 32'hDEAD_BEEF);
      drive(4'b0000, 4'b0000, -1, 32'h0, 32'h0, (j == 4), 1'b0, 32'h0);
      tick();
    end
    check_out("stall_wait", 0, 0, 32'h0000_3000, 32'hCAFE_0003, 0, 0, 1, 3, 32'hDEAD_BEEF);
    drive(4'b0000, 4'b0000, -1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
    tick();
    check_out("stall_done", 0, 0, 32'h0000_3000, 32'hCAFE_0003, 0, 4'b1000, 0, 3, 32'hDEAD_BEEF);
    drive_idle();
    tick();
    check_out("stall_after", 0, 0, 32'h0000_3000, 32'hCAFE_0003, 0, 0, 0, 3, 32'hDEAD_BEEF);

    // Reset while master 2's read waits for completion.
    drive(4'b0000, 4'b0100, 2, 32'h0000_2200, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("rst_issue", 0, 1, 32'h0000_2200, 32'h0, 4'b0100, 0, 1, 2, 32'hDEAD_BEEF);
    drive(4'b0000, 4'b0000, 2, 32'h0000_2200, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    check_out("rst_wait", 0, 0, 32'h0000_2200, 32'h0, 0, 0, 1, 2, 32'hDEAD_BEEF);
    #2;
    reset = 1'b0;
    #1;
    check_out("rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(4'b0000, 4'b0000, -1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h9999_9999);
    tick();
    tick();
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check_out($sformatf("rst_after%0d", j), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // All four masters write continuously into a zero-wait slave.
    drive(4'b1111, 4'b0000, -1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    n_acc  = 0;
    last_c = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.cpu_s_access_ready != 4'b0000 && n_acc < 5) begin
        check($sformatf("rr%0d ready", n_acc), 32'(bus.cpu_s_access_ready),
              32'(4'b0001 << rr_order[n_acc]));
        check($sformatf("rr%0d grant_id", n_acc), 32'(arb_grant_id), 32'(rr_order[n_acc]));
        check($sformatf("rr%0d m_address", n_acc), bus.cpu_m_address,
              32'hF000_0000 | 32'(rr_order[n_acc]));
        check($sformatf("rr%0d m_write", n_acc), 32'(bus.cpu_m_write), 32'd1);
        if (n_acc > 0)
          check($sformatf("rr%0d spacing_ok(gap=%0d)", n_acc, c - last_c),
                32'((c - last_c) >= 2 && (c - last_c) <= 3), 32'd1);
        last_c = c;
        n_acc++;
      end
      tick();
    end
    check("rr accepts_seen", 32'(n_acc), 32'd5);
    drive_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
